// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: MIPS ID/EX pipeline register with EX/MEM operand bypass and load-use bubble insertion
// Ports: clk, reset (sync, active-low); id_* decoded instruction from ID; rf_addr1/2 -> RegFile,
// rf_data1/2 <- RegFile; ex_result / mem_* bypass sources; ex_hold freezes ID/EX, flush kills ID;
// stall_id holds PC and IF/ID; ex_* registered instruction for EX; bubble_cnt saturating load-use count.
module id_ex_operand_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [4:0]        id_dst,
    input  logic              id_reg_wr,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       id_imm,
    output logic [4:0]        rf_addr1,
    output logic [4:0]        rf_addr2,
    input  logic [31:0]       rf_data1,
    input  logic [31:0]       rf_data2,
    input  logic [31:0]       ex_result,
    input  logic              mem_valid,
    input  logic              mem_reg_wr,
    input  logic [4:0]        mem_dst,
    input  logic [31:0]       mem_result,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_dst,
    output logic              ex_reg_wr,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic        ex_fwd, mem_fwd, load_use;
    logic [31:0] op1, op2;

    assign rf_addr1 = id_rs;
    assign rf_addr2 = id_rt;

    // A load in EX has no data yet, so it is never an EX bypass source.
    assign ex_fwd  = ex_valid & ex_reg_wr & ~ex_mem_rd;
    assign mem_fwd = mem_valid & mem_reg_wr;

    always_comb begin
        op1 = (id_rs == 5'd0) ? 32'd0 : (ex_fwd && ex_dst == id_rs) ? ex_result :
              (mem_fwd && mem_dst == id_rs) ? mem_result : rf_data1;
        op2 = (id_rt == 5'd0) ? 32'd0 : (ex_fwd && ex_dst == id_rt) ? ex_result :
              (mem_fwd && mem_dst == id_rt) ? mem_result : rf_data2;
    end

    assign load_use = id_valid & ex_valid & ex_mem_rd & ex_reg_wr & (ex_dst != 5'd0) &
                      ((id_rs_used & (id_rs == ex_dst)) | (id_rt_used & (id_rt == ex_dst)));
    assign stall_id = ex_hold | (load_use & ~flush);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid   <= 1'b0;
            ex_op1     <= '0;
            ex_op2     <= '0;
            ex_imm     <= '0;
            ex_dst     <= '0;
            ex_reg_wr  <= 1'b0;
            ex_mem_rd  <= 1'b0;
            ex_mem_wr  <= 1'b0;
            ex_ctrl    <= '0;
            bubble_cnt <= '0;
        end else if (!ex_hold) begin
            if (flush || load_use) begin
                // Bubble: data fields are left as they were, only validity/side effects cleared.
                ex_valid  <= 1'b0;
                ex_reg_wr <= 1'b0;
                ex_mem_rd <= 1'b0;
                ex_mem_wr <= 1'b0;
                if (!flush && bubble_cnt != '1)
                    bubble_cnt <= bubble_cnt + 1'b1;
            end else begin
                ex_valid  <= id_valid;
                ex_op1    <= op1;
                ex_op2    <= op2;
                ex_imm    <= id_imm;
                ex_dst    <= id_dst;
                ex_reg_wr <= id_valid & id_reg_wr;
                ex_mem_rd <= id_valid & id_mem_rd;
                ex_mem_wr <= id_valid & id_mem_wr;
                ex_ctrl   <= id_ctrl;
            end
        end
    end
endmodule
